// File: rtl/axi_ddr_reader_pkg.sv
// Shared constants and types for the AXI DDR burst reader.
package axi_ddr_reader_pkg;
  localparam int BEAT_W    = 256;
  localparam int NUM_BEATS = 5;
  localparam int CNT_W     = 3;
  localparam logic [CNT_W-1:0] BEAT_CAP = CNT_W'(NUM_BEATS);

  localparam logic [7:0] AR_LEN   = 8'd4;
  localparam logic [2:0] AR_SIZE  = 3'b101;
  localparam logic [1:0] AR_BURST = 2'b01;
  localparam logic [3:0] AR_CACHE = 4'b0011;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;
endpackage

// File: rtl/axi_ddr_reader.sv
// Single-burst AXI read master: fetches five 256-bit beats into a 1280-bit word.
// Define AXI_DDR_READER_ADDR_INC_EN to step the read address by ADDR_STRIDE per read.
module axi_ddr_reader
  import axi_ddr_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STRIDE = 32'd160
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        start,
  output logic                        busy,
  output logic                        valid,
  output logic [NUM_BEATS*BEAT_W-1:0] data_out,
  output logic [31:0]                 M_AXI_araddr,
  output logic                        M_AXI_arvalid,
  input  logic                        M_AXI_arready,
  output logic [7:0]                  M_AXI_arlen,
  output logic [2:0]                  M_AXI_arsize,
  output logic [1:0]                  M_AXI_arburst,
  output logic [3:0]                  M_AXI_arcache,
  output logic [3:0]                  M_AXI_arqos,
  output logic [3:0]                  M_AXI_arid,
  output logic [1:0]                  M_AXI_arlock,
  output logic [2:0]                  M_AXI_arprot,
  input  logic [3:0]                  M_AXI_rid,
  input  logic [BEAT_W-1:0]           M_AXI_rdata,
  input  logic                        M_AXI_rlast,
  output logic                        M_AXI_rready,
  input  logic [1:0]                  M_AXI_rresp,
  input  logic                        M_AXI_rvalid
);

`ifdef AXI_DDR_READER_ADDR_INC_EN
  localparam logic [31:0] ADDR_STEP = ADDR_STRIDE;
`else
  localparam logic [31:0] ADDR_STEP = ADDR_STRIDE & 32'h0;
`endif

  state_e                             state, state_nxt;
  logic [NUM_BEATS-1:0][BEAT_W-1:0]   buffer, buf_nxt;
  logic [CNT_W-1:0]                   beat_cnt;
  logic [31:0]                        addr;
  logic                               beat_fire;
  logic                               unused_ok;

  assign unused_ok = ^{M_AXI_rid, M_AXI_rresp};

  assign M_AXI_arlen   = AR_LEN;
  assign M_AXI_arsize  = AR_SIZE;
  assign M_AXI_arburst = AR_BURST;
  assign M_AXI_arcache = AR_CACHE;
  assign M_AXI_arqos   = '0;
  assign M_AXI_arid    = '0;
  assign M_AXI_arlock  = '0;
  assign M_AXI_arprot  = '0;
  assign M_AXI_araddr  = addr;

  assign busy          = (state != IDLE);
  assign M_AXI_arvalid = (state == ADDR);
  assign M_AXI_rready  = (state == DATA);
  assign valid         = (state == DONE);
  assign beat_fire     = (state == DATA) && M_AXI_rvalid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ADDR;
      ADDR: if (M_AXI_arready) state_nxt = DATA;
      DATA: if (M_AXI_rvalid && M_AXI_rlast) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slices not reached by a short burst keep whatever the previous read left there.
  always_comb begin
    buf_nxt = buffer;
    if (beat_fire && beat_cnt < BEAT_CAP) buf_nxt[beat_cnt] = M_AXI_rdata;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      buffer   <= '0;
      beat_cnt <= '0;
      addr     <= BASE_ADDR;
      data_out <= '0;
    end else begin
      state  <= state_nxt;
      buffer <= buf_nxt;
      if (state == ADDR)
        beat_cnt <= '0;
      else if (beat_fire && beat_cnt < BEAT_CAP)
        beat_cnt <= beat_cnt + CNT_W'(1);
      // Load on the rlast beat so data_out is current during the valid cycle.
      if (state == DATA && state_nxt == DONE) data_out <= buf_nxt;
      if (state == DONE) addr <= addr + ADDR_STEP;
    end
  end

endmodule

// File: tb/tb_axi_ddr_reader.sv
// Directed bench for axi_ddr_reader with a small scripted AXI read slave.
module tb_axi_ddr_reader;
  import axi_ddr_reader_pkg::*;

  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'd160;

  logic          ACLK = 1'b0;
  logic          ARESETN, start, busy, valid;
  logic [1279:0] data_out;
  logic [31:0]   M_AXI_araddr;
  logic          M_AXI_arvalid, M_AXI_arready;
  logic [7:0]    M_AXI_arlen;
  logic [2:0]    M_AXI_arsize, M_AXI_arprot;
  logic [1:0]    M_AXI_arburst, M_AXI_arlock, M_AXI_rresp;
  logic [3:0]    M_AXI_arcache, M_AXI_arqos, M_AXI_arid, M_AXI_rid;
  logic [255:0]  M_AXI_rdata;
  logic          M_AXI_rlast, M_AXI_rready, M_AXI_rvalid;

  int n_chk = 0, n_fail = 0;
  int ar_cnt = 0, vld_cnt = 0;
  logic [31:0]  exp_addr;
  logic [255:0] exp_buf [5];

  axi_ddr_reader #(.BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .valid(valid),
    .data_out(data_out), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arvalid(M_AXI_arvalid),
    .M_AXI_arready(M_AXI_arready), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
    .M_AXI_arburst(M_AXI_arburst), .M_AXI_arcache(M_AXI_arcache), .M_AXI_arqos(M_AXI_arqos),
    .M_AXI_arid(M_AXI_arid), .M_AXI_arlock(M_AXI_arlock), .M_AXI_arprot(M_AXI_arprot),
    .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rlast(M_AXI_rlast),
    .M_AXI_rready(M_AXI_rready), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rvalid(M_AXI_rvalid)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (M_AXI_arvalid && M_AXI_arready) ar_cnt++;
    if (valid) vld_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ties();
    chk("arlen", 256'(M_AXI_arlen), 256'(8'd4));
    chk("arsize", 256'(M_AXI_arsize), 256'(3'b101));
    chk("arburst", 256'(M_AXI_arburst), 256'(2'b01));
    chk("arcache", 256'(M_AXI_arcache), 256'(4'b0011));
    chk("ar_zero_ties", 256'({M_AXI_arqos, M_AXI_arid, M_AXI_arlock, M_AXI_arprot}), 256'(0));
  endtask

  task automatic do_ar(input int delay);
    int w = 0;
    logic [31:0] a0;
    while (!M_AXI_arvalid && w < 20) begin @(negedge ACLK); w++; end
    chk("arvalid_up", 256'(M_AXI_arvalid), 256'(1));
    a0 = M_AXI_araddr;
    chk("araddr", 256'(a0), 256'(exp_addr));
    chk("arlen_burst", 256'(M_AXI_arlen), 256'(8'd4));
    for (int i = 0; i < delay; i++) begin
      @(negedge ACLK);
      chk("arvalid_hold", 256'(M_AXI_arvalid), 256'(1));
      chk("araddr_hold", 256'(M_AXI_araddr), 256'(a0));
    end
    M_AXI_arready = 1'b1;
    @(negedge ACLK);
    M_AXI_arready = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [255:0] base, input bit gap,
                            input bit last_en, input bit restart);
    int w;
    for (int k = 0; k < n; k++) begin
      M_AXI_rvalid = 1'b1;
      M_AXI_rdata  = base + 256'(k);
      M_AXI_rlast  = last_en && (k == n - 1);
      if (restart) start = (k == 2);
      w = 0;
      while (!M_AXI_rready && w < 50) begin @(negedge ACLK); w++; end
      if (w >= 50) chk("rready_timeout", 256'(0), 256'(1));
      if (k < 5) exp_buf[k] = base + 256'(k);
      @(negedge ACLK);
      if (gap && k < n - 1) begin
        M_AXI_rvalid = 1'b0;
        M_AXI_rlast  = 1'b0;
        start        = 1'b0;
        chk("busy_in_gap", 256'(busy), 256'(1));
        @(negedge ACLK);
      end
    end
    M_AXI_rvalid = 1'b0;
    M_AXI_rlast  = 1'b0;
    start        = 1'b0;
  endtask

  task automatic run_read(input int delay, input int n, input logic [255:0] base,
                          input bit gap, input bit restart);
    int a0 = ar_cnt, v0 = vld_cnt, w = 0;
    @(negedge ACLK); start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'(1));
    do_ar(delay);
    send_beats(n, base, gap, 1'b1, restart);
    while (!valid && w < 20) begin @(negedge ACLK); w++; end
    chk("valid_pulse", 256'(valid), 256'(1));
    for (int k = 0; k < 5; k++)
      chk($sformatf("data_out[%0d]", k), data_out[256*k +: 256], exp_buf[k]);
    @(negedge ACLK);
    chk("valid_one_cycle", 256'(valid), 256'(0));
    chk("busy_idle", 256'(busy), 256'(0));
    repeat (3) @(negedge ACLK);
    chk("ar_count", 256'(ar_cnt - a0), 256'(1));
    chk("valid_count", 256'(vld_cnt - v0), 256'(1));
    for (int k = 0; k < 5; k++)
      chk($sformatf("data_hold[%0d]", k), data_out[256*k +: 256], exp_buf[k]);
`ifdef AXI_DDR_READER_ADDR_INC_EN
    exp_addr = exp_addr + STRIDE;
`endif
  endtask

  initial begin
    ARESETN = 1'b0; start = 1'b0; M_AXI_arready = 1'b0;
    M_AXI_rid = 4'h3; M_AXI_rresp = 2'b10; M_AXI_rdata = '0;
    M_AXI_rlast = 1'b0; M_AXI_rvalid = 1'b0;
    exp_addr = BASE;
    for (int k = 0; k < 5; k++) exp_buf[k] = '0;

    repeat (2) @(negedge ACLK);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_valid", 256'(valid), 256'(0));
    chk("rst_arvalid", 256'(M_AXI_arvalid), 256'(0));
    chk("rst_rready", 256'(M_AXI_rready), 256'(0));
    chk("rst_data_nonzero", 256'(|data_out), 256'(0));
    chk("rst_araddr", 256'(M_AXI_araddr), 256'(BASE));
    chk_ties();
    ARESETN = 1'b1;
    repeat (7) @(negedge ACLK);

    // start pulse lands at t=100 ns; beats 1..5
    run_read(0, 5, 256'h1, 1'b0, 1'b0);
    // arready held off 10 cycles
    run_read(10, 5, 256'h101, 1'b0, 1'b0);
    // beats on alternate cycles
    run_read(0, 5, 256'h201, 1'b1, 1'b0);
    // start re-pulsed while in DATA
    run_read(0, 5, 256'h30, 1'b0, 1'b1);

    // reset after two beats
    @(negedge ACLK); start = 1'b1;
    @(negedge ACLK); start = 1'b0;
    do_ar(0);
    send_beats(2, 256'h20, 1'b0, 1'b0, 1'b0);
    ARESETN = 1'b0;
    #1;
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_valid", 256'(valid), 256'(0));
    chk("midrst_arvalid", 256'(M_AXI_arvalid), 256'(0));
    chk("midrst_rready", 256'(M_AXI_rready), 256'(0));
    chk("midrst_data_nonzero", 256'(|data_out), 256'(0));
    chk("midrst_araddr", 256'(M_AXI_araddr), 256'(BASE));
    exp_addr = BASE;
    for (int k = 0; k < 5; k++) exp_buf[k] = '0;
    @(negedge ACLK); ARESETN = 1'b1;
    run_read(0, 5, 256'h10, 1'b0, 1'b0);

    // short burst: slices 3,4 keep 0x13/0x14 from the previous read
    run_read(0, 3, 256'hA0, 1'b0, 1'b0);
    chk("short_slice3", data_out[3*256 +: 256], 256'h13);
    chk("short_slice0", data_out[0 +: 256], 256'hA0);
    // long burst: beats 6 and 7 discarded
    run_read(2, 7, 256'hB0, 1'b0, 1'b0);
    chk("long_slice4", data_out[4*256 +: 256], 256'hB4);
    chk_ties();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_ddr_reader.md
AXI_DDR_READER -- requirements
Module: axi_ddr_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first read.
REQ-002 SHALL have parameter ADDR_STRIDE, default 32'd160, address increment per completed read (used only under REQ-033).
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a read.
REQ-006 SHALL have port busy  out  1  high while a read is in progress.
REQ-007 SHALL have port valid  out  1  one-cycle pulse when data_out is updated.
REQ-008 SHALL have port data_out  out  1280  five assembled 256-bit beats.
REQ-009 SHALL have port M_AXI_araddr  out  32  burst start address.
REQ-010 SHALL have port M_AXI_arvalid  out  1  address valid.
REQ-011 SHALL have port M_AXI_arready  in  1  address ready.
REQ-012 SHALL have port M_AXI_arlen  out  8  constant 8'd4 (5 beats).
REQ-013 SHALL have port M_AXI_arsize  out  3  constant 3'b101 (32 bytes).
REQ-014 SHALL have port M_AXI_arburst  out  2  constant 2'b01 (INCR).
REQ-015 SHALL have port M_AXI_arcache  out  4  constant 4'b0011.
REQ-016 SHALL have port M_AXI_arqos  out  4  constant 0.
REQ-017 SHALL have port M_AXI_arid  out  4  constant 0.
REQ-018 SHALL have port M_AXI_arlock  out  2  constant 0.
REQ-019 SHALL have port M_AXI_arprot  out  3  constant 0.
REQ-020 SHALL have port M_AXI_rid  in  4  read ID; ignored.
REQ-021 SHALL have port M_AXI_rdata  in  256  read beat data.
REQ-022 SHALL have port M_AXI_rlast  in  1  last beat of burst.
REQ-023 SHALL have port M_AXI_rready  out  1  read data ready.
REQ-024 SHALL have port M_AXI_rresp  in  2  read response; ignored.
REQ-025 SHALL have port M_AXI_rvalid  in  1  read data valid.

Function
REQ-026 SHALL implement FSM IDLE, ADDR, DATA, DONE; busy = (state != IDLE).
REQ-027 IDLE: start=1 SHALL go to ADDR next cycle; start while busy SHALL be ignored, not queued.
REQ-028 ADDR: arvalid=1, araddr stable until arready=1 is sampled; then go to DATA.
REQ-029 DATA: rready=1; each rvalid&rready beat k (k=0..4) SHALL be stored in buffer bits [256k+255:256k]; beats past the fifth SHALL be discarded; beat with rlast SHALL go to DONE.
REQ-030 DONE: data_out SHALL load the whole buffer, valid=1 for exactly one cycle, return to IDLE; data_out SHALL hold until the next DONE; rlast before 5 beats SHALL leave unwritten slices at their previous buffer values.

Reset
REQ-031 ARESETN=0 SHALL immediately force IDLE, arvalid=0, rready=0, busy=0, valid=0, data_out=0, buffer=0, beat count=0, address=BASE_ADDR, even mid-burst.

Configuration
REQ-032 Macro AXI_DDR_READER_ADDR_INC_EN SHALL select address behaviour.
REQ-033 Defined: araddr SHALL advance by ADDR_STRIDE at each DONE, wrapping modulo 2^32; undefined: every read SHALL use BASE_ADDR.

Structure
REQ-034 Package axi_ddr_reader_pkg SHALL hold BEAT_W=256, NUM_BEATS=5, AXI tie-off constants and the state enum.
REQ-035 SHALL be a single flat module; no sub-module.

Verification
REQ-036 Reset release, start pulse at t=100 ns, slave returns beats 256'h1..256'h5 -> arlen=4, araddr=BASE_ADDR, one valid pulse, data_out = {5,4,3,2,1} slices.
REQ-037 arready delayed 10 cycles -> arvalid and araddr held stable; single AR handshake.
REQ-038 rvalid gapped (beats on alternate cycles) -> same data_out; busy high throughout; valid one cycle.
REQ-039 start re-pulsed during DATA -> ignored; exactly one AR transaction and one valid.
REQ-040 ARESETN low mid-burst after beat 2 -> all outputs 0 next edge; new start after release completes normally.
REQ-041 With AXI_DDR_READER_ADDR_INC_EN, two reads -> araddr 0x0 then 0xA0; without the macro both 0x0.
